// File: rtl/matmul_result_checker_if.sv
// Handshake and data bundle between a matmul test driver and the on-chip result checker.
// The driver side owns start/config/matrices; the checker side owns status and results.
interface matmul_result_checker_if #(
    parameter int BUS_WIDTH = 16,
    parameter int MAX_DIM   = 4
);
    localparam int N  = MAX_DIM * MAX_DIM;
    localparam int DW = $clog2(MAX_DIM + 1);
    localparam int CW = $clog2(N + 1);
    localparam int RW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

    logic                   start;
    logic                   mask_mode;
    logic [DW-1:0]          dim_rows;
    logic [DW-1:0]          dim_cols;
    logic [N*BUS_WIDTH-1:0] res_flat;
    logic [N*BUS_WIDTH-1:0] exp_flat;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [CW-1:0]          err_count;
    logic                   first_err_valid;
    logic [RW-1:0]          first_err_row;
    logic [RW-1:0]          first_err_col;
    logic [15:0]            test_count;

    modport master (
        output start, mask_mode, dim_rows, dim_cols, res_flat, exp_flat,
        input  busy, done, pass, err_count, first_err_valid,
               first_err_row, first_err_col, test_count
    );

    modport slave (
        input  start, mask_mode, dim_rows, dim_cols, res_flat, exp_flat,
        output busy, done, pass, err_count, first_err_valid,
               first_err_row, first_err_col, test_count
    );
endinterface

// File: rtl/matmul_result_checker.sv
// On-chip result checker: snapshots result and golden matrices, scans them LANES elements per
// cycle with optional active-region masking and a signed tolerance, and reports the outcome.
module matmul_result_checker #(
    parameter int BUS_WIDTH = 16,
    parameter int MAX_DIM   = 4,
    parameter int LANES     = 1,
    parameter int TOL       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    matmul_result_checker_if.slave  bus
);
    localparam int N  = MAX_DIM * MAX_DIM;
    localparam int DW = $clog2(MAX_DIM + 1);
    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N + 1);
    localparam int RW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam int LW = $clog2(LANES + 1);
    localparam int FW = BUS_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t                 state;
    logic [N*BUS_WIDTH-1:0] res_q;
    logic [N*BUS_WIDTH-1:0] exp_q;
    logic                   mask_q;
    logic [DW-1:0]          rows_q;
    logic [DW-1:0]          cols_q;
    logic [IW-1:0]          idx;
    logic [CW-1:0]          err_count;
    logic                   first_valid;
    logic [RW-1:0]          first_row;
    logic [RW-1:0]          first_col;
    logic                   pass;
    logic                   done;
    logic                   busy;
    logic [15:0]            test_count;

    logic [LANES-1:0]       lane_mis;
    logic [IW-1:0]          lane_e [LANES];
    logic [LW-1:0]          hit_count;
    logic                   hit_any;
    logic [IW-1:0]          hit_e;

    // The difference is taken one bit wider than the data so extreme operands never wrap.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IW-1:0]                e;
        logic [IW-1:0]                row;
        logic [IW-1:0]                col;
        logic signed [BUS_WIDTH-1:0]  r;
        logic signed [BUS_WIDTH-1:0]  x;
        logic signed [FW-1:0]         diff;
        logic [FW-1:0]                mag;
        logic                         active;

        assign e        = idx + IW'(l);
        assign row      = e / IW'(MAX_DIM);
        assign col      = e % IW'(MAX_DIM);
        assign r        = res_q[e*BUS_WIDTH +: BUS_WIDTH];
        assign x        = exp_q[e*BUS_WIDTH +: BUS_WIDTH];
        assign diff     = {r[BUS_WIDTH-1], r} - {x[BUS_WIDTH-1], x};
        assign mag      = diff[FW-1] ? FW'(-diff) : FW'(diff);
        assign active   = !mask_q || ((row < IW'(rows_q)) && (col < IW'(cols_q)));
        assign lane_mis[l] = active && (mag > FW'(TOL));
        assign lane_e[l]   = e;
    end

    // Walk lanes from high to low so the lowest mismatching lane is the one left in hit_e.
    always_comb begin
        hit_count = '0;
        hit_any   = 1'b0;
        hit_e     = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_mis[l]) begin
                hit_count = hit_count + LW'(1);
                hit_any   = 1'b1;
                hit_e     = lane_e[l];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            res_q       <= '0;
            exp_q       <= '0;
            mask_q      <= 1'b0;
            rows_q      <= '0;
            cols_q      <= '0;
            idx         <= '0;
            err_count   <= '0;
            first_valid <= 1'b0;
            first_row   <= '0;
            first_col   <= '0;
            pass        <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            test_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        res_q       <= bus.res_flat;
                        exp_q       <= bus.exp_flat;
                        mask_q      <= bus.mask_mode;
                        rows_q      <= (bus.dim_rows > DW'(MAX_DIM)) ? DW'(MAX_DIM) : bus.dim_rows;
                        cols_q      <= (bus.dim_cols > DW'(MAX_DIM)) ? DW'(MAX_DIM) : bus.dim_cols;
                        idx         <= '0;
                        err_count   <= '0;
                        first_valid <= 1'b0;
                        first_row   <= '0;
                        first_col   <= '0;
                        busy        <= 1'b1;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    err_count <= err_count + CW'(hit_count);
                    if (hit_any && !first_valid) begin
                        first_valid <= 1'b1;
                        first_row   <= RW'(hit_e / IW'(MAX_DIM));
                        first_col   <= RW'(hit_e % IW'(MAX_DIM));
                    end
                    idx <= idx + IW'(LANES);
                    if (idx == IW'(N - LANES)) begin
                        state <= REPORT;
                    end
                end
                REPORT: begin
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    pass       <= (err_count == '0);
                    test_count <= test_count + 16'd1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy            = busy;
    assign bus.done            = done;
    assign bus.pass            = pass;
    assign bus.err_count       = err_count;
    assign bus.first_err_valid = first_valid;
    assign bus.first_err_row   = first_row;
    assign bus.first_err_col   = first_col;
    assign bus.test_count      = test_count;
endmodule
